// File: rtl/clint_timer.sv
// Machine timer / software-interrupt unit: 64-bit mtime with prescaler, mtimecmp, msip,
// single-entry response buffer and gated interrupt request with mcause.
module clint_timer #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned PRESCALE = 1
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [15:0]     req_addr,
   input  logic [31:0]     req_wdata,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [31:0]     resp_rdata,
   output logic            resp_error,
   input  logic            mstatus_mie,
   input  logic            mie_msie,
   input  logic            mie_mtie,
   output logic            msip,
   output logic            mtip,
   output logic            irq,
   output logic [XLEN-1:0] irq_cause
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   typedef enum logic [2:0] {
      REG_MSIP,
      REG_CMP_LO,
      REG_CMP_HI,
      REG_TIME_LO,
      REG_TIME_HI,
      REG_NONE
   } reg_sel_e;

   logic [63:0]   mtime_q, mtime_nxt;
   logic [63:0]   mtimecmp_q;
   logic          msip_q;
   logic          mtip_q;
   logic [PW-1:0] presc_q;
   logic          resp_valid_q;
   logic [31:0]   resp_rdata_q;
   logic          resp_error_q;
   reg_sel_e      sel;
   logic [31:0]   rd_data;
   logic          accept;
   logic          wr;
   logic          wrap;

   assign req_ready  = !resp_valid_q || resp_ready;
   assign accept     = req_valid && req_ready;
   assign wr         = accept && req_write;
   assign wrap       = (presc_q == PS_LAST);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_error = resp_error_q;
   assign msip       = msip_q;
   assign mtip       = mtip_q;

   // Low two address bits are don't-care in every pattern.
   always_comb begin
      sel = REG_NONE;
      casez (req_addr)
         16'b0000_0000_0000_00??: sel = REG_MSIP;
         16'b0100_0000_0000_00??: sel = REG_CMP_LO;
         16'b0100_0000_0000_01??: sel = REG_CMP_HI;
         16'b1011_1111_1111_10??: sel = REG_TIME_LO;
         16'b1011_1111_1111_11??: sel = REG_TIME_HI;
         default:                 sel = REG_NONE;
      endcase
   end

   always_comb begin
      rd_data = '0;
      case (sel)
         REG_MSIP:    rd_data = {31'b0, msip_q};
         REG_CMP_LO:  rd_data = mtimecmp_q[31:0];
         REG_CMP_HI:  rd_data = mtimecmp_q[63:32];
         REG_TIME_LO: rd_data = mtime_q[31:0];
         REG_TIME_HI: rd_data = mtime_q[63:32];
         default:     rd_data = '0;
      endcase
   end

   // A write to either mtime half suppresses the whole 64-bit increment.
   always_comb begin
      mtime_nxt = mtime_q;
      if (wr && sel == REG_TIME_LO)
         mtime_nxt = {mtime_q[63:32], req_wdata};
      else if (wr && sel == REG_TIME_HI)
         mtime_nxt = {req_wdata, mtime_q[31:0]};
      else if (wrap)
         mtime_nxt = mtime_q + 64'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mtime_q      <= '0;
         mtimecmp_q   <= '1;
         msip_q       <= 1'b0;
         mtip_q       <= 1'b0;
         presc_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_error_q <= 1'b0;
      end else begin
         mtime_q <= mtime_nxt;
         presc_q <= wrap ? '0 : presc_q + PW'(1);
         mtip_q  <= (mtime_q >= mtimecmp_q);
         if (wr && sel == REG_MSIP)   msip_q            <= req_wdata[0];
         if (wr && sel == REG_CMP_LO) mtimecmp_q[31:0]  <= req_wdata;
         if (wr && sel == REG_CMP_HI) mtimecmp_q[63:32] <= req_wdata;
         if (accept) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= req_write ? '0 : rd_data;
            resp_error_q <= (sel == REG_NONE);
         end else if (resp_ready) begin
            resp_valid_q <= 1'b0;
         end
      end
   end

   always_comb begin
      irq       = 1'b0;
      irq_cause = '0;
      if (mstatus_mie && msip_q && mie_msie) begin
         irq                  = 1'b1;
         irq_cause[XLEN-1]    = 1'b1;
         irq_cause[3:0]       = 4'd3;
      end else if (mstatus_mie && mtip_q && mie_mtie) begin
         irq                  = 1'b1;
         irq_cause[XLEN-1]    = 1'b1;
         irq_cause[3:0]       = 4'd7;
      end
   end

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (PRESCALE 1 and 4) on a shared bus, checked every
// cycle against a behavioural model plus directed constant checks.
module tb_clint_timer;

   logic        clock;
   logic        reset_n;
   logic        req_valid;
   logic        req_write;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_ready;
   logic        mstatus_mie;
   logic        mie_msie;
   logic        mie_mtie;

   logic        o_req_ready[2];
   logic        o_resp_valid[2];
   logic [31:0] o_resp_rdata[2];
   logic        o_resp_error[2];
   logic        o_msip[2];
   logic        o_mtip[2];
   logic        o_irq[2];
   logic [31:0] o_cause[2];

   int unsigned checks;
   int unsigned errors;

   clint_timer #(.XLEN(32), .PRESCALE(1)) dut0 (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(o_req_ready[0]), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(o_resp_valid[0]), .resp_ready(resp_ready),
      .resp_rdata(o_resp_rdata[0]), .resp_error(o_resp_error[0]),
      .mstatus_mie(mstatus_mie), .mie_msie(mie_msie), .mie_mtie(mie_mtie),
      .msip(o_msip[0]), .mtip(o_mtip[0]), .irq(o_irq[0]), .irq_cause(o_cause[0])
   );

   clint_timer #(.XLEN(32), .PRESCALE(4)) dut1 (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(o_req_ready[1]), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(o_resp_valid[1]), .resp_ready(resp_ready),
      .resp_rdata(o_resp_rdata[1]), .resp_error(o_resp_error[1]),
      .mstatus_mie(mstatus_mie), .mie_msie(mie_msie), .mie_mtie(mie_mtie),
      .msip(o_msip[1]), .mtip(o_mtip[1]), .irq(o_irq[1]), .irq_cause(o_cause[1])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model state
   logic [63:0] m_mt[2];
   int unsigned m_pc[2];
   logic        m_mtip[2];
   logic [31:0] m_rdata[2];
   logic [63:0] m_cmp;
   logic        m_msip;
   logic        m_rv;
   logic        m_err;

   function automatic int unsigned ps(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   function automatic bit mapped(input logic [15:0] wa);
      return wa == 16'h0000 || wa == 16'h4000 || wa == 16'h4004 ||
             wa == 16'hBFF8 || wa == 16'hBFFC;
   endfunction

   function automatic logic [31:0] read_val(input int k, input logic [15:0] wa);
      case (wa)
         16'h0000: return {31'b0, m_msip};
         16'h4000: return m_cmp[31:0];
         16'h4004: return m_cmp[63:32];
         16'hBFF8: return m_mt[k][31:0];
         16'hBFFC: return m_mt[k][63:32];
         default:  return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] exp_cause(input int k);
      if (mstatus_mie && m_msip && mie_msie) return 32'h8000_0003;
      if (mstatus_mie && m_mtip[k] && mie_mtie) return 32'h8000_0007;
      return 32'h0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mt[k] = 64'h0; m_pc[k] = 0; m_mtip[k] = 1'b0; m_rdata[k] = 32'h0;
      end
      m_cmp = '1; m_msip = 1'b0; m_rv = 1'b0; m_err = 1'b0;
   endtask

   task automatic chk(input string tag, input int k, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[dut%0d] observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk("req_ready",  k, o_req_ready[k],  !m_rv || resp_ready);
         chk("resp_valid", k, o_resp_valid[k], m_rv);
         chk("resp_rdata", k, o_resp_rdata[k], m_rdata[k]);
         chk("resp_error", k, o_resp_error[k], m_err);
         chk("msip",       k, o_msip[k],       m_msip);
         chk("mtip",       k, o_mtip[k],       m_mtip[k]);
         chk("irq",        k, o_irq[k],        exp_cause(k) != 32'h0);
         chk("irq_cause",  k, o_cause[k],      exp_cause(k));
      end
   endtask

   // One clock: predict next state from current inputs, clock, then compare.
   task automatic cycle();
      bit          acc;
      logic [15:0] wa;
      logic [63:0] nmt[2];
      int unsigned npc[2];
      logic        nmtip[2];
      logic [31:0] nrd[2];
      logic [63:0] ncmp;
      logic        nmsip, nrv, nerr;
      acc  = req_valid && (!m_rv || resp_ready);
      wa   = {req_addr[15:2], 2'b00};
      ncmp = m_cmp; nmsip = m_msip; nrv = m_rv; nerr = m_err;
      for (int k = 0; k < 2; k++) begin
         nmtip[k] = (m_mt[k] >= m_cmp);
         npc[k]   = (m_pc[k] + 1) % ps(k);
         nmt[k]   = (m_pc[k] == ps(k) - 1) ? m_mt[k] + 64'd1 : m_mt[k];
         nrd[k]   = m_rdata[k];
         if (acc && req_write && wa == 16'hBFF8) nmt[k] = {m_mt[k][63:32], req_wdata};
         if (acc && req_write && wa == 16'hBFFC) nmt[k] = {req_wdata, m_mt[k][31:0]};
         if (acc) nrd[k] = req_write ? 32'h0 : read_val(k, wa);
      end
      if (acc && req_write) begin
         if (wa == 16'h0000) nmsip = req_wdata[0];
         if (wa == 16'h4000) ncmp[31:0]  = req_wdata;
         if (wa == 16'h4004) ncmp[63:32] = req_wdata;
      end
      if (acc) begin
         nrv = 1'b1; nerr = !mapped(wa);
      end else if (resp_ready) begin
         nrv = 1'b0;
      end
      @(posedge clock);
      for (int k = 0; k < 2; k++) begin
         m_mt[k] = nmt[k]; m_pc[k] = npc[k]; m_mtip[k] = nmtip[k]; m_rdata[k] = nrd[k];
      end
      m_cmp = ncmp; m_msip = nmsip; m_rv = nrv; m_err = nerr;
      #1;
      check_all();
   endtask

   task automatic do_reset();
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clock);
      #1 check_all();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; resp_ready = 1'b1;
      cycle();
      req_valid = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a);
      req_valid = 1'b1; req_write = 1'b0; req_addr = a; resp_ready = 1'b1;
      cycle();
      req_valid = 1'b0;
   endtask

   function automatic logic [15:0] pick_addr();
      logic [15:0] base;
      case ($urandom_range(0, 6))
         0:       base = 16'h0000;
         1:       base = 16'h4000;
         2:       base = 16'h4004;
         3:       base = 16'hBFF8;
         4:       base = 16'hBFFC;
         5:       base = 16'h1000;
         default: base = 16'($urandom);
      endcase
      return {base[15:2], 2'($urandom_range(0, 3))};
   endfunction

   initial begin
      checks = 0; errors = 0;
      reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      resp_ready = 1'b1; mstatus_mie = 1'b0; mie_msie = 1'b0; mie_mtie = 1'b0;
      model_reset();
      do_reset();

      rd(16'h4004);
      chk("cmp_hi_reset", 0, o_resp_rdata[0], 32'hFFFF_FFFF);
      rd(16'h1000);
      chk("unmapped_err", 0, o_resp_error[0], 1'b1);
      chk("unmapped_data", 0, o_resp_rdata[0], 32'h0);

      // 64-bit carry on the PRESCALE=1 instance
      wr(16'hBFF8, 32'hFFFF_FFFF);
      wr(16'hBFFC, 32'h0000_0001);
      idle(2);
      rd(16'hBFF8);
      chk("carry_lo", 0, o_resp_rdata[0], 32'h0000_0001);
      rd(16'hBFFC);
      chk("carry_hi", 0, o_resp_rdata[0], 32'h0000_0002);

      // Prescale by 4: 12 cycles after zeroing mtime gives 3
      wr(16'hBFF8, 32'h0);
      wr(16'hBFFC, 32'h0);
      idle(12);
      rd(16'hBFF8);
      chk("prescale4", 1, o_resp_rdata[1], 32'd3);

      // Compare: mtip one cycle after mtime reaches 20
      mstatus_mie = 1'b1; mie_msie = 1'b1; mie_mtie = 1'b1;
      wr(16'h4000, 32'd20);
      wr(16'h4004, 32'd0);
      wr(16'hBFF8, 32'd0);
      wr(16'hBFFC, 32'd0);
      idle(20);
      chk("mtip_before", 0, o_mtip[0], 1'b0);
      idle(1);
      chk("mtip_rise", 0, o_mtip[0], 1'b1);
      chk("irq_rise", 0, o_irq[0], 1'b1);
      chk("cause_timer", 0, o_cause[0], 32'h8000_0007);
      wr(16'h4004, 32'hFFFF_FFFF);
      idle(1);
      chk("mtip_clear", 0, o_mtip[0], 1'b0);

      // Priority and gating
      wr(16'h4004, 32'h0);
      wr(16'h4000, 32'h0);
      idle(2);
      wr(16'h0000, 32'h1);
      chk("cause_sw", 0, o_cause[0], 32'h8000_0003);
      mie_msie = 1'b0;
      idle(1);
      chk("cause_msie_off", 0, o_cause[0], 32'h8000_0007);
      mstatus_mie = 1'b0;
      idle(1);
      chk("irq_mie_off", 0, o_irq[0], 1'b0);

      // Backpressure: pending response blocks new requests
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'hBFF8; resp_ready = 1'b0;
      cycle();
      req_addr = 16'h4000;
      repeat (5) begin
         cycle();
         chk("stall_ready", 0, o_req_ready[0], 1'b0);
      end
      resp_ready = 1'b1;
      cycle();
      chk("release_data", 0, o_resp_rdata[0], 32'h0);
      req_valid = 1'b0;

      // Reset with a response pending
      req_valid = 1'b1; req_addr = 16'h0000; resp_ready = 1'b0;
      cycle();
      req_valid = 1'b0;
      do_reset();
      chk("rst_resp_valid", 0, o_resp_valid[0], 1'b0);
      resp_ready = 1'b1;
      rd(16'h4004);
      chk("cmp_hi_after_rst", 1, o_resp_rdata[1], 32'hFFFF_FFFF);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         req_valid  = ($urandom_range(0, 3) != 0);
         req_write  = ($urandom_range(0, 2) == 0);
         req_addr   = pick_addr();
         req_wdata  = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 64);
         resp_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) begin
            mstatus_mie = 1'($urandom); mie_msie = 1'($urandom); mie_mtie = 1'($urandom);
         end
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
